// File: rtl/ram_pkg.sv
// Shared defaults and FSM encodings for the RAM burst reader.
package ram_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ADDRESS_WIDTH = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Command, stream and RAM-port signals of the burst reader.
// The master modport is the reader itself; slave is the side that drives commands.
interface ram_burst_reader_if import ram_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) ();

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [ADDRESS_WIDTH:0]   length;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     ram_wr_en;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_data_out;

  modport master (
    input  start, base_addr, length, out_ready, ram_data_out,
    output busy, done, out_data, out_valid, ram_wr_en, ram_addr
  );

  modport slave (
    output start, base_addr, length, out_ready, ram_data_out,
    input  busy, done, out_data, out_valid, ram_wr_en, ram_addr
  );

endinterface

// File: rtl/ram_burst_reader.sv
// Streams Length consecutive RAM words from BaseAddr through one registered
// valid/ready output stage, pausing under backpressure.
//
// state    | meaning
// ST_IDLE  | waiting for Start; zero-length Start only pulses done
// ST_READ  | words remain to be fetched into the output register
// ST_DRAIN | last word loaded, waiting for its handshake
module ram_burst_reader import ram_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input logic                i_clk,
  input logic                i_rst_n,
  ram_burst_reader_if.master bus
);

  localparam logic [ADDRESS_WIDTH:0] REM_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  logic [1:0]               r_state;
  logic                     r_busy;
  logic                     r_done;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic                     r_out_valid;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_rem;

  logic w_handshake;
  logic w_load;

  assign w_handshake = r_out_valid && bus.out_ready;
  // The output register may be refilled in the same cycle it is consumed.
  assign w_load = (r_state == ST_READ) && (r_rem != '0) &&
                  (!r_out_valid || bus.out_ready);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_addr      <= '0;
      r_rem       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              r_addr  <= bus.base_addr;
              r_rem   <= bus.length;
              r_state <= ST_READ;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_load) begin
            r_out_data  <= bus.ram_data_out;
            r_out_valid <= 1'b1;
            r_addr      <= r_addr + 1'b1;
            r_rem       <= r_rem - REM_ONE;
            if (r_rem == REM_ONE) begin
              r_state <= ST_DRAIN;
            end
          end else if (w_handshake) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.ram_wr_en = 1'b0;
  assign bus.ram_addr  = r_addr;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: bursts push expected words into a queue,
// an independent monitor pops them on every handshake.
module tb_ram_burst_reader;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_burst_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
  logic [DW-1:0] mem [DEPTH];

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.ram_data_out = mem[bus.ram_addr];

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q [$];
  int            exp_done = 0;
  int            done_seen = 0;
  int            rdy_mode = 0;
  int            rdy_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [AW-1:0] base, input logic [AW:0] len);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    tick();
    bus.start = 1'b0;
  endtask

  // Reference model: a burst is simply len words read from consecutive addresses mod DEPTH.
  task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] len);
    drive_start(base, len);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(mem[AW'(int'(base) + i)]);
    end
    exp_done++;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_seen < exp_done && c < budget) begin
      tick();
      c++;
    end
    check("done_timeout", done_seen, exp_done);
  endtask

  // Downstream ready: always 1, random, or the repeating 1,0,0,1,0,1 pattern.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          bus.out_ready = (rdy_idx % 6 == 0) || (rdy_idx % 6 == 3) || (rdy_idx % 6 == 5);
          rdy_idx++;
        end
      endcase
    end
  end

  // Monitor: handshakes pop the scoreboard; stalls must hold data and address.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, prev_data);
          check("stall_addr", bus.ram_addr, prev_addr);
        end
        if (bus.out_valid && bus.out_ready) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check("word_data", bus.out_data, exp_q.pop_front());
          end
        end
        if (bus.done) begin
          done_seen++;
          check("done_after_last_word", exp_q.size(), 0);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_addr  = bus.ram_addr;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int            busy_cyc;
    int            valid_cyc;
    int            first_valid;
    int            c;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [AW-1:0] model_addr;

    for (int k = 0; k < DEPTH; k++) mem[k] = 16'hA000 + 16'(k);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    rdy_mode      = 0;
    rst_n         = 1'b0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wr_en", bus.ram_wr_en, 0);
    rst_n = 1'b1;
    tick();

    // Basic burst: latency, busy length and bubble-free streaming.
    start_burst(10'd5, 11'd4);
    busy_cyc = 0;
    valid_cyc = 0;
    first_valid = -1;
    while (bus.busy && busy_cyc < 20) begin
      if (bus.out_valid) begin
        if (first_valid < 0) begin
          first_valid = busy_cyc;
          check("basic_first_word", bus.out_data, 16'hA005);
        end
        valid_cyc++;
      end
      busy_cyc++;
      tick();
    end
    check("basic_busy_cycles", busy_cyc, 5);
    check("basic_valid_cycles", valid_cyc, 4);
    check("basic_first_valid_at", first_valid, 1);
    check("basic_done_pulse", bus.done, 1);
    tick();
    check("basic_done_cleared", bus.done, 0);
    wait_done(10);

    // Backpressure with the 1,0,0,1,0,1 pattern.
    rdy_idx = 0;
    rdy_mode = 2;
    start_burst(10'd5, 11'd4);
    wait_done(100);

    // Address wrap-around.
    rdy_mode = 1;
    start_burst(10'd1022, 11'd4);
    wait_done(100);
    check("wrap_end_addr", bus.ram_addr, 10'd2);

    // Zero length: done next cycle, no busy, no data.
    rdy_mode = 0;
    start_burst(10'd7, 11'd0);
    check("zero_done", bus.done, 1);
    check("zero_busy", bus.busy, 0);
    tick();
    check("zero_done_cleared", bus.done, 0);
    check("zero_busy_after", bus.busy, 0);
    check("zero_no_valid", bus.out_valid, 0);
    check("zero_addr_hold", bus.ram_addr, 10'd2);
    wait_done(10);

    // Full depth.
    start_burst(10'd0, 11'd1024);
    wait_done(1100);
    check("full_end_addr", bus.ram_addr, 10'd0);

    // Start while busy is ignored.
    rdy_idx = 0;
    rdy_mode = 2;
    start_burst(10'd5, 11'd8);
    tick();
    tick();
    drive_start(10'd100, 11'd3);
    wait_done(100);
    check("busy_start_end_addr", bus.ram_addr, 10'd13);

    // Back-to-back: Start accepted in the Done cycle.
    rdy_mode = 0;
    start_burst(10'd50, 11'd3);
    c = 0;
    while (!bus.done && c < 20) begin
      tick();
      c++;
    end
    check("b2b_done_seen", bus.done, 1);
    start_burst(10'd600, 11'd3);
    tick();
    check("b2b_first_valid", bus.out_valid, 1);
    check("b2b_first_data", bus.out_data, mem[600]);
    wait_done(50);

    // Reset in the middle of a burst.
    start_burst(10'd200, 11'd6);
    tick();
    tick();
    check("rst_mid_words_left", exp_q.size(), 5);
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_addr", bus.ram_addr, 0);
    check("rst_mid_done", bus.done, 0);
    exp_q.delete();
    exp_done--;
    rst_n = 1'b1;
    tick();
    check("rst_mid_no_done", done_seen, exp_done);
    start_burst(10'd300, 11'd6);
    wait_done(50);

    // Randomized bursts against the model.
    model_addr = 10'd306;
    for (int it = 0; it < 30; it++) begin
      if (it % 4 == 0) begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 16'($urandom);
      end
      base = 10'($urandom);
      len  = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 48));
      rdy_mode = int'($urandom_range(0, 2));
      start_burst(base, len);
      wait_done(400);
      if (len != 0) model_addr = AW'(int'(base) + int'(len));
      check("rand_end_addr", bus.ram_addr, model_addr);
      check("rand_wr_en", bus.ram_wr_en, 0);
    end

    repeat (3) tick();
    check("end_queue_empty", exp_q.size(), 0);
    check("end_done_count", done_seen, exp_done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
